uart_tx_periph: RTL and testbench

UART_TX_PERIPH -- requirements
Module: uart_tx_periph

---
 rtl/uart_pkg.sv | 32 +++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/uart_tx_periph.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_periph.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit peripheral.
//   tx_state_e    - transmit FSM state encoding
//   RegData/RegStatus - CPU register offsets (A1)
//   Stat*         - STATUS register bit indices
//   status_word() - packs the STATUS register read value
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  localparam logic RegData   = 1'b0;
  localparam logic RegStatus = 1'b1;

  localparam int unsigned StatTxBusy    = 0;
  localparam int unsigned StatFifoFull  = 1;
  localparam int unsigned StatFifoEmpty = 2;

  function automatic logic [15:0] status_word(input logic busy, input logic full,
                                              input logic empty);
    logic [15:0] w_word;
    w_word                = '0;
    w_word[StatTxBusy]    = busy;
    w_word[StatFifoFull]  = full;
    w_word[StatFifoEmpty] = empty;
    return w_word;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through read data.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   push, din  - write request and data (ignored while full)
//   pop        - read request (ignored while empty)
//   dout       - head entry, valid whenever empty is low
//   full/empty - derived from the registered occupancy count
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign dout   = r_mem[r_rptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: 68000-bus UART transmitter (8N1, LSB first) with a transmit FIFO.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   cs, as_n, rw      - select, address strobe (active low), 1 = read
//   lds_n, addr       - lower data strobe (active low), A1 (0 = DATA, 1 = STATUS)
//   din               - write data D7..D0
//   dout              - registered read data
//   dtack_n           - registered transfer acknowledge (active low)
//   txd               - registered serial output, idle high
module uart_tx_periph
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        as_n,
  input  logic        rw,
  input  logic        lds_n,
  input  logic        addr,
  input  logic [7:0]  din,
  output logic [15:0] dout,
  output logic        dtack_n,
  output logic        txd
);

  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BaudLast = BW'(CLKS_PER_BIT - 1);

  // FIFO
  logic       w_fifo_push;
  logic       w_fifo_pop;
  logic [7:0] w_fifo_dout;
  logic       w_fifo_full;
  logic       w_fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_fifo_push),
    .pop   (w_fifo_pop),
    .din   (din),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // Bus interface
  logic        r_ack;
  logic        r_armed;  // as_n seen high since reset; blocks a stale strobe
  logic        r_dtack_n;
  logic [15:0] r_dout;
  logic        w_access;
  logic        w_data_wr;
  logic        w_ack;
  logic        w_tx_busy;

  assign w_access  = cs & ~as_n & ~r_ack & r_armed;
  assign w_data_wr = ~rw & (addr == RegData) & ~lds_n;
  // A full FIFO stalls a data write: no ack until space appears.
  assign w_ack       = w_access & ~(w_data_wr & w_fifo_full);
  assign w_fifo_push = w_ack & w_data_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack     <= 1'b0;
      r_armed   <= 1'b0;
      r_dtack_n <= 1'b1;
      r_dout    <= '0;
    end else if (as_n) begin
      r_ack     <= 1'b0;
      r_armed   <= 1'b1;
      r_dtack_n <= 1'b1;
    end else if (w_ack) begin
      r_ack     <= 1'b1;
      r_dtack_n <= 1'b0;
      if (rw) begin
        r_dout <= (addr == RegStatus) ? status_word(w_tx_busy, w_fifo_full, w_fifo_empty)
                                      : 16'h0000;
      end
    end
  end

  assign dout    = r_dout;
  assign dtack_n = r_dtack_n;

  // Transmit FSM
  tx_state_e   r_state, w_state_d;
  logic [BW-1:0] r_baud, w_baud_d;
  logic [2:0]  r_bit, w_bit_d;
  logic [7:0]  r_shift, w_shift_d;
  logic        r_txd, w_txd_d;
  logic        w_baud_end;

  assign w_baud_end = (r_baud == BaudLast);
  assign w_tx_busy  = (r_state != StIdle);

  always_comb begin
    w_state_d  = r_state;
    w_baud_d   = r_baud + BW'(1);
    w_bit_d    = r_bit;
    w_shift_d  = r_shift;
    w_fifo_pop = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_baud_d = '0;
        if (!w_fifo_empty) begin
          w_fifo_pop = 1'b1;
          w_shift_d  = w_fifo_dout;
          w_state_d  = StStart;
        end
      end
      StStart: begin
        if (w_baud_end) begin
          w_baud_d  = '0;
          w_bit_d   = '0;
          w_state_d = StData;
        end
      end
      StData: begin
        if (w_baud_end) begin
          w_baud_d  = '0;
          w_shift_d = {1'b0, r_shift[7:1]};
          w_bit_d   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_d = StStop;
        end
      end
      StStop: begin
        if (w_baud_end) begin
          w_baud_d = '0;
          // Back-to-back frames: reload straight into START with no idle gap.
          if (!w_fifo_empty) begin
            w_fifo_pop = 1'b1;
            w_shift_d  = w_fifo_dout;
            w_state_d  = StStart;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: begin
        w_state_d = StIdle;
        w_baud_d  = '0;
      end
    endcase
  end

  // txd is derived from the next state so the registered line tracks the state register.
  always_comb begin
    w_txd_d = 1'b1;
    case (w_state_d)
      StStart: w_txd_d = 1'b0;
      StData:  w_txd_d = w_shift_d[0];
      default: w_txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_baud  <= w_baud_d;
      r_bit   <= w_bit_d;
      r_shift <= w_shift_d;
      r_txd   <= w_txd_d;
    end
  end

  assign txd = r_txd;

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph: scoreboard bench for uart_tx_periph (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Stimulus pushes expected serial bytes and read data into queues; two monitors
// (serial receiver, read-cycle watcher) pop and compare.
module tb_uart_tx_periph;

  localparam int unsigned Cpb   = 4;
  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        as_n;
  logic        rw;
  logic        lds_n;
  logic        addr;
  logic [7:0]  din;
  logic [15:0] dout;
  logic        dtack_n;
  logic        txd;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;

  logic [7:0]  exp_tx[$];
  logic [15:0] exp_rd[$];
  int unsigned start_cyc[$];
  logic        mon_busy = 1'b0;
  logic        mon_abort;
  logic        mon_start;
  logic        mon_stop;
  logic [7:0]  mon_rx;
  logic        rd_prev_dtack = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_periph #(
    .CLKS_PER_BIT (Cpb),
    .FIFO_DEPTH   (Depth)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cs      (cs),
    .as_n    (as_n),
    .rw      (rw),
    .lds_n   (lds_n),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .dtack_n (dtack_n),
    .txd     (txd)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One bus cycle; returns how many extra cycles dtack_n was withheld.
  task automatic bus_access(input logic a, input logic rd, input logic lds, input logic [7:0] d,
                            input int hold, output int waited);
    @(negedge clk);
    cs = 1'b1; as_n = 1'b0; rw = rd; addr = a; lds_n = lds; din = d;
    waited = 0;
    @(negedge clk);
    while (dtack_n === 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("dtack_asserted", 16'(dtack_n), 16'h0000);
    repeat (hold) @(negedge clk);
    if (hold > 0) check("dtack_held", 16'(dtack_n), 16'h0000);
    as_n = 1'b1; cs = 1'b0;
    @(negedge clk);
    check("dtack_release", 16'(dtack_n), 16'h0001);
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((exp_tx.size() != 0 || mon_busy) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 16'(n < bound), 16'h0001);
    repeat (4) @(negedge clk);
  endtask

  // Read monitor: compares dout on each falling dtack_n of a read.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_prev_dtack && dtack_n === 1'b0 && rw) begin
        if (exp_rd.size() == 0) check("unexpected_read", dout, 16'hxxxx);
        else check("read_dout", dout, exp_rd.pop_front());
      end
      rd_prev_dtack = dtack_n;
    end
  end

  // Serial monitor: samples each bit mid-period; a reset inside the frame drops it.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && txd === 1'b0) begin
        mon_busy  = 1'b1;
        mon_abort = 1'b0;
        start_cyc.push_back(cyc);
        repeat (2) begin @(negedge clk); mon_abort |= rst; end
        mon_start = txd;
        for (int i = 0; i < 8; i++) begin
          repeat (Cpb) begin @(negedge clk); mon_abort |= rst; end
          mon_rx[i] = txd;
        end
        repeat (Cpb) begin @(negedge clk); mon_abort |= rst; end
        mon_stop = txd;
        @(negedge clk);
        mon_abort |= rst;
        if (mon_abort) begin
          if (exp_tx.size() > 0) void'(exp_tx.pop_front());
        end else if (exp_tx.size() == 0) begin
          check("unexpected_frame", 16'(mon_rx), 16'hxxxx);
        end else begin
          check("tx_start_bit", 16'(mon_start), 16'h0000);
          check("tx_byte", 16'(mon_rx), 16'(exp_tx.pop_front()));
          check("tx_stop_bit", 16'(mon_stop), 16'h0001);
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n0;
    logic [7:0] burst [6];
    logic [7:0] quad [4];
    burst = '{8'hA1, 8'h02, 8'hC3, 8'h44, 8'hE5, 8'h66};
    quad  = '{8'h10, 8'h20, 8'h30, 8'h40};

    rst = 1'b1; cs = 1'b0; as_n = 1'b1; rw = 1'b1; lds_n = 1'b1; addr = 1'b0; din = '0;
    repeat (3) @(negedge clk);
    check("reset_txd", 16'(txd), 16'h0001);
    check("reset_dtack", 16'(dtack_n), 16'h0001);
    check("reset_dout", dout, 16'h0000);
    rst = 1'b0;

    // STATUS at idle, then DATA read
    exp_rd.push_back(16'h0004);
    bus_access(1'b1, 1'b1, 1'b0, 8'h00, 0, w);
    check("status_latency", 16'(w), 16'h0000);
    exp_rd.push_back(16'h0000);
    bus_access(1'b0, 1'b1, 1'b0, 8'h00, 0, w);

    // Single frame 0x55
    n0 = start_cyc.size();
    exp_tx.push_back(8'h55);
    bus_access(1'b0, 1'b0, 1'b0, 8'h55, 0, w);
    check("write_latency", 16'(w), 16'h0000);
    wait_drain(200);
    check("frames_55", 16'(start_cyc.size() - n0), 16'h0001);

    // Burst: one byte leaves for the shift register at once, so the 4-deep FIFO
    // only fills when the 6th write arrives; that write waits for the next pop.
    n0 = start_cyc.size();
    for (int i = 0; i < 6; i++) begin
      exp_tx.push_back(burst[i]);
      bus_access(1'b0, 1'b0, 1'b0, burst[i], 2, w);
      if (i < 5) check("burst_latency", 16'(w), 16'h0000);
      else check("burst_withheld", 16'(w >= 8), 16'h0001);
    end
    wait_drain(600);
    check("frames_burst", 16'(start_cyc.size() - n0), 16'h0006);
    for (int k = 1; k < 6; k++) begin
      check("frame_spacing", 16'(start_cyc[n0 + k] - start_cyc[n0 + k - 1]), 16'(10 * Cpb));
    end

    // STATUS mid-frame with 3 bytes queued
    for (int i = 0; i < 4; i++) begin
      exp_tx.push_back(quad[i]);
      bus_access(1'b0, 1'b0, 1'b0, quad[i], 0, w);
    end
    exp_rd.push_back(16'h0001);
    bus_access(1'b1, 1'b1, 1'b0, 8'h00, 0, w);
    wait_drain(400);

    // Long strobe queues exactly one byte
    n0 = start_cyc.size();
    exp_tx.push_back(8'h3C);
    bus_access(1'b0, 1'b0, 1'b0, 8'h3C, 20, w);
    wait_drain(200);
    check("frames_long_strobe", 16'(start_cyc.size() - n0), 16'h0001);

    // lds_n high: acknowledged, no side effect
    n0 = start_cyc.size();
    bus_access(1'b0, 1'b0, 1'b1, 8'h99, 0, w);
    check("lds_high_latency", 16'(w), 16'h0000);
    repeat (60) @(negedge clk);
    check("frames_lds_high", 16'(start_cyc.size() - n0), 16'h0000);
    exp_rd.push_back(16'h0004);
    bus_access(1'b1, 1'b1, 1'b0, 8'h00, 0, w);

    // Reset during DATA state and during a bus cycle
    exp_tx.push_back(8'h0F);
    bus_access(1'b0, 1'b0, 1'b0, 8'h0F, 0, w);
    repeat (14) @(negedge clk);
    exp_rd.push_back(16'h0005);
    cs = 1'b1; as_n = 1'b0; rw = 1'b1; addr = 1'b1; lds_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_dtack", 16'(dtack_n), 16'h0000);
    rst = 1'b1;
    @(negedge clk);
    check("midframe_reset_txd", 16'(txd), 16'h0001);
    check("midbus_reset_dtack", 16'(dtack_n), 16'h0001);
    check("midbus_reset_dout", dout, 16'h0000);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("no_rearm_dtack", 16'(dtack_n), 16'h0001);
    as_n = 1'b1; cs = 1'b0;
    @(negedge clk);
    exp_rd.push_back(16'h0004);
    bus_access(1'b1, 1'b1, 1'b0, 8'h00, 0, w);
    wait_drain(100);
    check("rd_queue_empty", 16'(exp_rd.size()), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
